fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, width of program counter and branch target.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_data  input  16  instruction word from instruction memory.
REQ-006 SHALL have port mem_ready  input  1  memory has mem_data valid for the current mem_read request.
REQ-007 SHALL have port ID  input  7  instruction ID from the instruction decoder, driven combinationally from instr_reg.
REQ-008 SHALL have port exec_done  input  1  datapath has finished the current instruction.
REQ-009 SHALL have port branch_taken  input  1  branch resolved taken; sampled only with exec_done.
REQ-010 SHALL have port branch_target  input  PC_WIDTH  new PC when branch_taken.
REQ-011 SHALL have port resume  input  1  asynchronous user button; releases PAUSE.
REQ-012 SHALL have port pc  output  PC_WIDTH  instruction memory address.
REQ-013 SHALL have port mem_read  output  1  instruction fetch request.
REQ-014 SHALL have port instr_reg  output  16  latched instruction, drives the decoder.
REQ-015 SHALL have port exec_start  output  1  one-cycle pulse starting datapath execution.
REQ-016 SHALL have port halted, paused, illegal  output  1 each  status flags.

Function
REQ-017 SHALL implement states RESET, FETCH, WAIT_MEM, DECODE, EXECUTE, PAUSE, HALT; registered Moore outputs, one-hot or binary encoding free.
REQ-018 RESET SHALL transition unconditionally to FETCH on the first clock after reset deasserts.
REQ-019 FETCH SHALL assert mem_read and go to WAIT_MEM next cycle.
REQ-020 WAIT_MEM SHALL keep mem_read high; on mem_ready SHALL load instr_reg <= mem_data, pc <= pc+1 (wraps all-ones -> 0), go DECODE; otherwise stay, indefinitely.
REQ-021 DECODE SHALL last exactly one cycle, sampling ID: 75 (HLT) -> HALT; 70 (PAUSE) -> PAUSE; 122, 125, 126, 127 -> HALT with illegal=1; 100 -> RESET (pc <= RESET_VECTOR); any other ID, including 78 -> EXECUTE.
REQ-022 Entry into EXECUTE SHALL assert exec_start for exactly the first cycle in EXECUTE.
REQ-023 EXECUTE SHALL wait for exec_done; on exec_done SHALL go FETCH, loading pc <= branch_target if branch_taken, else keeping the incremented pc.
REQ-024 exec_done in the same cycle as exec_start SHALL be accepted (single-cycle instructions: DECODE->EXECUTE->FETCH).
REQ-025 branch_taken without exec_done, or outside EXECUTE, SHALL be ignored.
REQ-026 resume SHALL pass through a 2-flop synchronizer plus rising-edge detector; in PAUSE a detected rising edge -> FETCH; edges outside PAUSE SHALL be discarded, a level held high since before PAUSE entry SHALL not release it.
REQ-027 HALT SHALL be absorbing; only reset exits; instr_reg and pc frozen.
REQ-028 paused=1 exactly while in PAUSE; halted=1 exactly while in HALT; illegal sticky until reset.
REQ-029 mem_read SHALL be 0 in every state except FETCH and WAIT_MEM; instr_reg SHALL change only in WAIT_MEM on mem_ready.
REQ-030 Minimum instruction latency SHALL be 4 cycles (FETCH, WAIT_MEM with mem_ready on first cycle, DECODE, EXECUTE with exec_done).

Reset
REQ-031 reset low SHALL immediately force state RESET, pc=RESET_VECTOR, instr_reg=16'hFFFF, mem_read=0, exec_start=0, halted=0, paused=0, illegal=0, synchronizer flops=0.
REQ-032 reset asserted mid-WAIT_MEM or mid-EXECUTE SHALL abandon the transaction; a late mem_ready/exec_done after release SHALL have no effect before FETCH.

Verification
REQ-033 Reset release, mem_ready on first WAIT_MEM cycle, mem_data=16'h2005 (non-halt), exec_done with exec_start -> mem_read high cycles 1-2, exec_start at cycle 4, pc=1 then second fetch at cycle 5.
REQ-034 mem_ready delayed 3 cycles -> mem_read held 4 cycles, instr_reg unchanged until mem_ready, pc increments once.
REQ-035 EXECUTE with exec_done+branch_taken, branch_target=16'h0800 -> next FETCH drives pc=16'h0800; branch_taken alone two cycles earlier ignored.
REQ-036 ID=70 -> paused=1, mem_read=0; resume held high into PAUSE -> stays; resume low then high -> FETCH within 4 cycles, paused=0.
REQ-037 ID=127 -> halted=1, illegal=1, remains through 100 cycles of exec_done/resume toggling; reset low -> all outputs to reset values; pc=16'hFFFF fetch -> pc wraps to 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer: fetches a word, classifies it by
// decoder ID, and hands off to the datapath, with pause/resume and halt.
module fetch_sequencer #(
  parameter int unsigned         PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         mem_data,
  input  logic                mem_ready,
  input  logic [6:0]          ID,
  input  logic                exec_done,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] pc,
  output logic                mem_read,
  output logic [15:0]         instr_reg,
  output logic                exec_start,
  output logic                halted,
  output logic                paused,
  output logic                illegal
);

  // state    | meaning
  // RESET    | one idle cycle after reset or a soft-reset instruction
  // FETCH    | issue mem_read
  // WAIT_MEM | hold mem_read until mem_ready, latch instruction
  // DECODE   | classify ID
  // EXECUTE  | datapath busy until exec_done
  // PAUSE    | wait for a fresh resume rising edge
  // HALT     | absorbing, only reset exits
  typedef enum logic [6:0] {
    S_RESET    = 7'b0000001,
    S_FETCH    = 7'b0000010,
    S_WAIT_MEM = 7'b0000100,
    S_DECODE   = 7'b0001000,
    S_EXECUTE  = 7'b0010000,
    S_PAUSE    = 7'b0100000,
    S_HALT     = 7'b1000000
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [15:0]         r_instr;
  logic                r_exec_start;
  logic                r_illegal;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_resume_q;
  logic                w_resume_rise;
  logic                w_id_illegal;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_resume_rise = r_sync2 & ~r_resume_q;
  assign w_id_illegal  = (ID == 7'd122) || (ID == 7'd125) ||
                         (ID == 7'd126) || (ID == 7'd127);
  assign w_pc_inc      = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:    w_next = S_FETCH;
      S_FETCH:    w_next = S_WAIT_MEM;
      S_WAIT_MEM: if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (ID == 7'd75 || w_id_illegal) w_next = S_HALT;
        else if (ID == 7'd70)            w_next = S_PAUSE;
        else if (ID == 7'd100)           w_next = S_RESET;
        else                             w_next = S_EXECUTE;
      end
      S_EXECUTE:  if (exec_done) w_next = S_FETCH;
      S_PAUSE:    if (w_resume_rise) w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_RESET;
    endcase
  end

  always_comb begin
    mem_read = 1'b0;
    halted   = 1'b0;
    paused   = 1'b0;
    case (r_state)
      S_FETCH, S_WAIT_MEM: mem_read = 1'b1;
      S_PAUSE:             paused   = 1'b1;
      S_HALT:              halted   = 1'b1;
      default:             ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc         <= RESET_VECTOR;
      r_instr      <= 16'hFFFF;
      r_exec_start <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_exec_start <= (r_state == S_DECODE) && (w_next == S_EXECUTE);
      if (r_state == S_WAIT_MEM && mem_ready) begin
        r_instr <= mem_data;
        r_pc    <= w_pc_inc;
      end
      if (r_state == S_EXECUTE && exec_done && branch_taken) r_pc <= branch_target;
      if (r_state == S_DECODE && ID == 7'd100) r_pc <= RESET_VECTOR;
      if (r_state == S_DECODE && w_id_illegal) r_illegal <= 1'b1;
    end
  end

  // resume is an unsynchronised button; only a rising edge seen in PAUSE counts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_resume_q <= 1'b0;
    end else begin
      r_sync1    <= resume;
      r_sync2    <= r_sync1;
      r_resume_q <= r_sync2;
    end
  end

  assign pc         = r_pc;
  assign instr_reg  = r_instr;
  assign exec_start = r_exec_start;
  assign illegal    = r_illegal;

endmodule
